// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcodes, PSR flag indices, FSM states and decode record for the execute controller.
package alu_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int OPCODE_WIDTH = 8;
  localparam int REG_ADDR_WIDTH = 4;
  localparam logic [7:0] ALU_AND  = 8'h01;
  localparam logic [7:0] ALU_OR   = 8'h02;
  localparam logic [7:0] ALU_XOR  = 8'h03;
  localparam logic [7:0] ALU_ADD  = 8'h05;
  localparam logic [7:0] ALU_ADDC = 8'h07;
  localparam logic [7:0] ALU_SUB  = 8'h09;
  localparam logic [7:0] ALU_CMP  = 8'h0B;
  localparam logic [7:0] ALU_MOV  = 8'h0D;
  localparam logic [7:0] ALU_LSH  = 8'h84;
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;
  typedef struct packed {
    logic [7:0] opcode;
    logic       use_imm;
    logic       sign_ext;
    logic       wr_rf;
    logic       wr_psr;
    logic       use_carry;
    logic       illegal;
  } dec_t;
  // Low nibble codes shared by the register-form opext and the immediate-form op field.
  function automatic logic is_alu_code(input logic [3:0] c);
    return {4'h0, c} inside {ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_ADDC, ALU_SUB, ALU_CMP, ALU_MOV};
  endfunction
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational instruction decode into ALU opcode and writeback/PSR controls.
module alu_seq_decode
  import alu_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_t        dec_o
);
  logic [3:0] op;
  logic [3:0] ext;
  logic       reg_form;
  logic       shift_form;
  logic       imm_form;
  logic       bad;
  logic [7:0] code;
  assign op         = instr_i[15:12];
  assign ext        = instr_i[7:4];
  assign reg_form   = op == 4'h0 && is_alu_code(ext);
  assign shift_form = op == 4'h8 && ext == 4'h4;
  assign imm_form   = is_alu_code(op);
  assign bad        = !(reg_form || shift_form || imm_form);
  assign code       = reg_form ? {4'h0, ext} : shift_form ? ALU_LSH : imm_form ? {4'h0, op} : 8'h00;
  assign dec_o.opcode    = code;
  assign dec_o.use_imm   = imm_form;
  assign dec_o.sign_ext  = imm_form && code inside {ALU_ADD, ALU_ADDC, ALU_SUB, ALU_CMP};
  assign dec_o.wr_rf     = !bad && code != ALU_CMP;
  assign dec_o.wr_psr    = !bad && code != ALU_MOV;
  assign dec_o.use_carry = code == ALU_ADDC;
  assign dec_o.illegal   = bad;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: IDLE->READ->EXEC->WB execute sequencer driving the ALU, register file and PSR.
// Define ALU_SEQ_CTRL_OVERLAP_EN to also accept in WB (one instruction per 3 cycles).
module alu_seq_ctrl #(
  parameter int WORD_WIDTH     = alu_pkg::WORD_WIDTH,
  parameter int OPCODE_WIDTH   = alu_pkg::OPCODE_WIDTH,
  parameter int REG_ADDR_WIDTH = alu_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr_a,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr_b,
  input  logic [WORD_WIDTH-1:0]     rf_rdata_a,
  input  logic [WORD_WIDTH-1:0]     rf_rdata_b,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [WORD_WIDTH-1:0]     rf_wdata,
  output logic [WORD_WIDTH-1:0]     alu_a,
  output logic [WORD_WIDTH-1:0]     alu_b,
  output logic [OPCODE_WIDTH-1:0]   alu_opcode,
  output logic                      alu_carry,
  input  logic [WORD_WIDTH-1:0]     alu_z,
  input  logic [4:0]                alu_flags,
  output logic [4:0]                psr,
  output logic                      done,
  output logic                      illegal
);
  import alu_pkg::*;
  state_t                  state_q, state_d;
  logic [15:0]             instr_q;
  logic [WORD_WIDTH-1:0]   alu_a_q, alu_b_q, res_q, imm_ext;
  logic [OPCODE_WIDTH-1:0] alu_opcode_q;
  logic                    alu_carry_q, accept, wb;
  logic [4:0]              flags_q, psr_q, psr_d;
  dec_t                    dec;
  alu_seq_decode u_dec (
    .instr_i(instr_q),
    .dec_o  (dec)
  );
`ifdef ALU_SEQ_CTRL_OVERLAP_EN
  // The WB-edge RF write and PSR update land before the next READ samples, so no hazard.
  assign instr_ready = state_q == ST_IDLE || state_q == ST_WB;
`else
  assign instr_ready = state_q == ST_IDLE;
`endif
  assign accept  = instr_valid && instr_ready;
  assign wb      = state_q == ST_WB;
  assign imm_ext = dec.sign_ext ? {{(WORD_WIDTH-8){instr_q[7]}}, instr_q[7:0]}
                                : {{(WORD_WIDTH-8){1'b0}}, instr_q[7:0]};
  always_comb begin
    state_d = accept ? ST_READ : state_q == ST_READ ? ST_EXEC : state_q == ST_EXEC ? ST_WB : ST_IDLE;
    psr_d   = wb && dec.wr_psr ? {flags_q[FLAG_N], flags_q[FLAG_Z], flags_q[FLAG_F], flags_q[FLAG_L], flags_q[FLAG_C]}
                               : psr_q;
  end
  assign rf_raddr_a = state_q == ST_READ ? REG_ADDR_WIDTH'(instr_q[11:8]) : '0;
  assign rf_raddr_b = state_q == ST_READ ? REG_ADDR_WIDTH'(instr_q[3:0]) : '0;
  assign rf_we      = wb && dec.wr_rf;
  assign rf_waddr   = wb ? REG_ADDR_WIDTH'(instr_q[11:8]) : '0;
  assign rf_wdata   = !wb ? '0 : dec.opcode == ALU_MOV ? alu_b_q : res_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_carry  = alu_carry_q;
  assign psr        = psr_q;
  assign done       = wb;
  assign illegal    = wb && dec.illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_carry_q  <= 1'b0;
      res_q        <= '0;
      flags_q      <= '0;
      psr_q        <= '0;
    end else begin
      state_q <= state_d;
      psr_q   <= psr_d;
      if (accept) instr_q <= instr;
      // Operands are registered straight onto the ALU ports so EXEC sees them and they hold afterwards.
      if (state_q == ST_READ) begin
        alu_a_q      <= rf_rdata_a;
        alu_b_q      <= dec.use_imm ? imm_ext : rf_rdata_b;
        alu_opcode_q <= OPCODE_WIDTH'(dec.opcode);
        alu_carry_q  <= dec.use_carry && psr_q[FLAG_C];
      end
      if (state_q == ST_EXEC) begin
        res_q   <= alu_z;
        flags_q <= alu_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench with behavioural register file, ALU and ISA model.
module tb_alu_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0, instr_ready;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata, alu_a, alu_b, alu_z;
  logic        rf_we, alu_carry, done, illegal;
  logic [7:0]  alu_opcode;
  logic [4:0]  alu_flags, psr;
  typedef struct {logic we; logic [3:0] wa; logic [15:0] wd; logic [4:0] psr; logic ill;} exp_t;
  exp_t        q[$];
  logic [15:0] rf[16];
  logic [15:0] mregs[16];
  logic [4:0]  mpsr = '0, psr_exp = '0;
  bit          psr_pend = 0;
  int          checks = 0, errors = 0, cyc = 0;
`ifdef ALU_SEQ_CTRL_OVERLAP_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 4;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_carry(alu_carry), .alu_z(alu_z), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal)
  );
  function automatic logic [20:0] ref_alu(input logic [7:0] op, input logic [15:0] a, b, input logic c);
    logic [16:0] s;
    logic [15:0] z;
    s = '0;
    z = '0;
    case (op)
      8'h01: z = a & b;
      8'h02: z = a | b;
      8'h03: z = a ^ b;
      8'h05: s = {1'b0, a} + {1'b0, b};
      8'h07: s = {1'b0, a} + {1'b0, b} + {16'h0, c};
      8'h09, 8'h0B: s = {1'b0, a} - {1'b0, b};
      8'h0D: z = b;
      8'h84: z = a << b[3:0];
      default: z = '0;
    endcase
    if (op inside {8'h05, 8'h07, 8'h09, 8'h0B}) z = s[15:0];
    return {z[15], z == 16'h0, 1'b0, a < b, s[16], z};
  endfunction
  assign {alu_flags, alu_z} = ref_alu(alu_opcode, alu_a, alu_b, alu_carry);
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];
  function automatic exp_t mexec(input logic [15:0] w);
    logic [3:0] op, rd, ext, rs;
    logic [7:0] code;
    logic [15:0] b;
    logic [20:0] r;
    exp_t e;
    op = w[15:12]; rd = w[11:8]; ext = w[7:4]; rs = w[3:0];
    e.ill = 1'b0;
    if (op == 4'h0 && ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD}) begin
      code = {4'h0, ext}; b = mregs[rs];
    end else if (op == 4'h8 && ext == 4'h4) begin
      code = 8'h84; b = mregs[rs];
    end else if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD}) begin
      code = {4'h0, op};
      b = op inside {4'h5, 4'h7, 4'h9, 4'hB} ? {{8{w[7]}}, w[7:0]} : {8'h00, w[7:0]};
    end else begin
      e.ill = 1'b1; code = '0; b = '0;
    end
    r = ref_alu(code, mregs[rd], b, code == 8'h07 ? mpsr[0] : 1'b0);
    e.wa = rd;
    e.we = !e.ill && code != 8'h0B;
    e.wd = code == 8'h0D ? b : r[15:0];
    if (!e.ill && code != 8'h0D) mpsr = r[20:16];
    e.psr = mpsr;
    if (e.we) mregs[rd] = e.wd;
    return e;
  endfunction
  task automatic rf_proc;
    logic we_s;
    logic [3:0] a_s;
    logic [15:0] d_s;
    forever begin
      @(negedge clk);
      we_s = rf_we; a_s = rf_waddr; d_s = rf_wdata;
      @(posedge clk);
      if (we_s) rf[a_s] = d_s;
    end
  endtask
  task automatic monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      if (psr_pend) begin
        checks++;
        if (psr !== psr_exp) begin errors++; $display("FAIL psr_update: got %h expected %h", psr, psr_exp); end
        psr_pend = 0;
      end
      if (rst_n && done) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL unexpected_done: done with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          if ({rf_we, illegal} !== {e.we, e.ill})
            begin errors++; $display("FAIL retire_ctrl: got we/ill=%b%b expected %b%b", rf_we, illegal, e.we, e.ill); end
          if (e.we) begin
            checks++;
            if ({rf_waddr, rf_wdata} !== {e.wa, e.wd})
              begin errors++; $display("FAIL writeback: got R%0d=%h expected R%0d=%h", rf_waddr, rf_wdata, e.wa, e.wd); end
          end
          psr_exp = e.psr; psr_pend = 1;
        end
      end
    end
  endtask
  task automatic set_reg(input int r, input logic [15:0] v);
    rf[r] = v; mregs[r] = v;
  endtask
  task automatic issue(input logic [15:0] w, input bit push, output int acc);
    bit r;
    acc = -1;
    if (push) q.push_back(mexec(w));
    instr = w; instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = instr_ready;
      @(posedge clk); #1;
      if (r) begin acc = cyc; return; end
    end
    checks++; errors++; $display("FAIL accept: instr %h not accepted within 20 cycles", w);
  endtask
  task automatic wait_idle;
    instr_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q.size() == 0 && instr_ready && !psr_pend) return;
    end
    checks++; errors++; $display("FAIL drain: %0d results still pending after 40 cycles", q.size());
  endtask
  task automatic test_reset;
    int acc;
    repeat (2) @(negedge clk);
    checks++;
    if ({psr, done, illegal, rf_we, alu_opcode} !== '0)
      begin errors++; $display("FAIL reset_outputs: got psr=%h done=%b ill=%b we=%b op=%h expected all 0", psr, done, illegal, rf_we, alu_opcode); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    set_reg(1, 16'h0003); set_reg(2, 16'h0004);
    issue(16'h0152, 0, acc);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_opcode !== 8'h05) begin errors++; $display("FAIL abort_exec_op: got %h expected 05", alu_opcode); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({psr, rf_we, done, alu_opcode} !== '0)
      begin errors++; $display("FAIL abort_reset: got psr=%h we=%b done=%b op=%h expected all 0", psr, rf_we, done, alu_opcode); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rf[1] !== 16'h0003) begin errors++; $display("FAIL abort_no_write: got R1=%h expected 0003", rf[1]); end
    checks++;
    if ({instr_ready, psr} !== 6'b1_00000) begin errors++; $display("FAIL abort_after: got ready=%b psr=%h expected 1/00", instr_ready, psr); end
  endtask
  task automatic test_add;
    int acc;
    set_reg(1, 16'h0003); set_reg(2, 16'h0004);
    issue(16'h0152, 1, acc);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({alu_opcode, alu_a, alu_b, alu_carry, done} !== {8'h05, 16'h0003, 16'h0004, 1'b0, 1'b0})
      begin errors++; $display("FAIL add_exec: got op=%h a=%h b=%h c=%b done=%b expected 05/0003/0004/0/0", alu_opcode, alu_a, alu_b, alu_carry, done); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || cyc - acc + 1 != 3)
      begin errors++; $display("FAIL add_latency: got done=%b at cycle %0d expected done=1 at cycle 3", done, cyc - acc + 1); end
    wait_idle();
  endtask
  task automatic test_cmpi;
    int acc;
    set_reg(3, 16'h0010);
    issue(16'hB3FF, 1, acc);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({alu_opcode, alu_a, alu_b} !== {8'h0B, 16'h0010, 16'hFFFF})
      begin errors++; $display("FAIL cmpi_exec: got op=%h a=%h b=%h expected 0B/0010/FFFF", alu_opcode, alu_a, alu_b); end
    wait_idle();
  endtask
  task automatic test_addc;
    int acc;
    set_reg(6, 16'hFFFF); set_reg(7, 16'h0001); set_reg(4, 16'h1000); set_reg(8, 16'h0000);
    issue(16'h0657, 1, acc);
    wait_idle();
    issue(16'h0472, 1, acc);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_carry !== 1'b1) begin errors++; $display("FAIL addc_carry_set: got %b expected 1", alu_carry); end
    wait_idle();
    issue(16'h5801, 1, acc);
    wait_idle();
    issue(16'h0472, 1, acc);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_carry !== 1'b0) begin errors++; $display("FAIL addc_carry_clr: got %b expected 0", alu_carry); end
    wait_idle();
  endtask
  task automatic test_movi_illegal;
    int acc;
    issue(16'hD5A0, 1, acc);
    wait_idle();
    issue(16'hF000, 1, acc);
    instr_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({done, illegal, rf_we} !== 3'b110)
      begin errors++; $display("FAIL illegal_pulse: got done/ill/we=%b%b%b expected 110", done, illegal, rf_we); end
    wait_idle();
  endtask
  task automatic test_back_to_back;
    int a1, a2;
    set_reg(9, 16'h0100); set_reg(10, 16'h0023); set_reg(11, 16'h0001);
    issue(16'h095A, 1, a1);
    issue(16'h0B59, 1, a2);
    instr_valid = 1'b0;
    checks++;
    if (a2 - a1 != GAP) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected %0d", a2 - a1, GAP); end
    wait_idle();
  endtask
  task automatic test_rf_final;
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (rf[r] !== mregs[r]) begin errors++; $display("FAIL rf_final: got R%0d=%h expected %h", r, rf[r], mregs[r]); end
    end
  endtask
  initial begin
    for (int r = 0; r < 16; r++) set_reg(r, 16'h0000);
    fork
      monitor();
      rf_proc();
    join_none
    test_reset();
    test_add();
    test_cmpi();
    test_addc();
    test_movi_illegal();
    test_back_to_back();
    test_rf_final();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle execute controller that sequences the 16-bit ALU for the CS3710 datapath. It accepts one instruction word per handshake and decodes register and immediate forms. It reads operands from the register file, drives the ALU's a/b/opcode/carry, and writes the result back. It owns the 5-bit processor status register (PSR) and updates it from the ALU flags.

Parameters:
WORD_WIDTH, 16, datapath and ALU word width
OPCODE_WIDTH, 8, ALU opcode width
REG_ADDR_WIDTH, 4, register-file address width (16 registers)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  16  [15:12] op, [11:8] Rdest, [7:4] opext, [3:0] Rsrc; imm8 = [7:0]
instr_valid  in  1  instr presented
instr_ready  out  1  controller can accept
rf_raddr_a  out  4  read address A (Rdest)
rf_raddr_b  out  4  read address B (Rsrc)
rf_rdata_a  in  16  combinational read data A
rf_rdata_b  in  16  combinational read data B
rf_we  out  1  register write strobe
rf_waddr  out  4  write address
rf_wdata  out  16  write data
alu_a  out  16  ALU operand a
alu_b  out  16  ALU operand b
alu_opcode  out  8  ALU opcode
alu_carry  out  1  ALU carry-in
alu_z  in  16  ALU result
alu_flags  in  5  ALU flags {N,Z,F,L,C} = [4:0]
psr  out  5  current status flags
done  out  1  one-cycle pulse: instruction retired
illegal  out  1  one-cycle pulse with done: undecodable instruction

Behaviour:
- Reset (async, rst_n=0): state IDLE; psr, alu_*, rf_*, done and illegal all 0. instr_ready=1 once rst_n deasserts. Reset mid-instruction aborts it: no write, no PSR change.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to READ.
- READ: drive rf_raddr_a=Rdest and rf_raddr_b=Rsrc. Capture rf_rdata_a into opA. Capture opB as rf_rdata_b (register form) or imm8 (immediate form).
- Immediate extension: sign-extended for ADDI/ADDCI/SUBI/CMPI; zero-extended for ANDI/ORI/XORI/MOVI.
- EXEC: alu_a=opA, alu_b=opB, alu_opcode=decoded code, alu_carry=psr[0] for ADDC/ADDCI, else 0. Register alu_z and alu_flags at the end of the cycle.
- WB: rf_we=1, rf_waddr=Rdest, rf_wdata=registered result; psr <= registered flags; done=1.
- WB exceptions: CMP/CMPI update psr only (rf_we=0). MOV/MOVI write opB and leave psr unchanged.
- Decode, register form (op=0000): ALU opcode = {0000, opext}. Legal opext: AND 0001, OR 0010, XOR 0011, ADD 0101, ADDC 0111, SUB 1001, CMP 1011, MOV 1101.
- Decode, shift: op=1000 with opext=0100 -> LSH, opcode 1000_0100.
- Decode, immediate form: op in {0001,0010,0011,0101,0111,1001,1011,1101} -> ALU opcode {0000, op}, imm8 operand.
- Illegal: any other encoding goes through all states with rf_we=0 and psr unchanged; done=1 and illegal=1 in WB.
- Latency: accept at edge T, done high in cycle T+3; throughput 1 per 4 cycles.
- alu_* outputs hold their last values outside EXEC; only the EXEC values are meaningful.
- instr_valid held with instr_ready=0: no effect; the instruction is taken on the next IDLE.

Optional Feature:
ALU_SEQ_CTRL_OVERLAP_EN
- Defined: instr_ready=1 in WB as well as IDLE. Accept in WB goes directly to READ, giving throughput 1 per 3 cycles.
- No hazard: the RF write commits at the WB edge, before the next READ samples. The new instruction's ADDC reads the PSR updated at that same edge.
- Undefined: instr_ready only in IDLE.

Decomposition:
- Package alu_pkg: WORD_WIDTH/OPCODE_WIDTH constants, ALU opcode constants (ADD, SUB, CMP, AND, OR, XOR, MOV, LSH, ADDC), flag bit indices (FLAG_C=0, FLAG_L=1, FLAG_F=2, FLAG_Z=3, FLAG_N=4), FSM state encoding.
- Sub-module alu_seq_decode: combinational; instr -> {alu_opcode, use_imm, sign_ext, wr_rf, wr_psr, use_carry, illegal}.

Test Plan:
- Reset: rst_n low mid-EXEC of ADD R1,R2 -> state IDLE, psr=0, rf_we never asserts, instr_ready=1 after release.
- Register ADD: instr=0x0152 (ADD R1,R2), R1=0x0003, R2=0x0004. Required: alu_opcode=0x05 in EXEC; rf_we/waddr=1/wdata=alu_z; done at T+3; psr=alu_flags.
- CMPI sign-extend: instr=0xB3FF, R3=0x0010. Required: alu_b=0xFFFF, alu_opcode=0x0B, rf_we=0, psr updated.
- ADDC carry: psr[0]=1, instr=0x0472 -> alu_carry=1. psr[0]=0 -> alu_carry=0.
- MOVI/illegal: 0xD5A0 -> R5 written with 0x00A0, psr unchanged. 0xF000 -> illegal=1 and done=1 in one cycle, no write.
- Back-to-back: instr_valid held for two instructions. Without the macro: second accepted 4 cycles after the first. With ALU_SEQ_CTRL_OVERLAP_EN: 3 cycles after, and reads the first instruction's written value.
